reg_rename_file: RTL and testbench

//  Architectural register file with per-register rename tags; consumer of the ROB commit-to-register stream.

---
 rtl/reg_rename_file_pkg.sv | 7 +
 rtl/reg_rename_file_query.sv | 25 ++
 rtl/reg_rename_file.sv | 67 ++++++
 tb/tb_reg_rename_file.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/reg_rename_file_pkg.sv
// reg_rename_file_pkg: shared widths for the rename register file
package reg_rename_file_pkg;
  localparam int XLEN = 32;
  localparam int REG_W = 5;
  localparam int ROB_W = 4;
  localparam int REG_NUM = 1 << REG_W;
endpackage

// File: rtl/reg_rename_file_query.sv
// reg_query_port: combinational source read with x0 forcing and same-cycle commit bypass
module reg_query_port
  import reg_rename_file_pkg::*;
(
  input  logic [REG_W-1:0] id,
  input  logic [XLEN-1:0]  reg_value,
  input  logic             reg_busy,
  input  logic [ROB_W-1:0] reg_tag,
  input  logic             commit_reg_config,
  input  logic [REG_W-1:0] commit_reg_id,
  input  logic [XLEN-1:0]  commit_reg_value,
  input  logic [ROB_W-1:0] commit_reg_rob,
  output logic [XLEN-1:0]  value,
  output logic             busy,
  output logic [ROB_W-1:0] rob
);
  logic zero, hit;
  always_comb begin
    zero = id == '0;
    hit = commit_reg_config && commit_reg_id == id && reg_busy && reg_tag == commit_reg_rob;
    value = zero ? '0 : hit ? commit_reg_value : reg_value;
    busy = !zero && !hit && reg_busy;
    rob = busy ? reg_tag : '0;
  end
endmodule

// File: rtl/reg_rename_file.sv
// reg_rename_file: architectural registers with per-register ROB rename tags
module reg_rename_file
  import reg_rename_file_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,
  input  logic             rename_config,
  input  logic [REG_W-1:0] rename_rd,
  input  logic [ROB_W-1:0] rename_rob,
  input  logic [REG_W-1:0] rs1_id,
  input  logic [REG_W-1:0] rs2_id,
  output logic [XLEN-1:0]  rs1_value,
  output logic [XLEN-1:0]  rs2_value,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic [ROB_W-1:0] rs1_rob,
  output logic [ROB_W-1:0] rs2_rob,
  input  logic             commit_reg_config,
  input  logic [REG_W-1:0] commit_reg_id,
  input  logic [XLEN-1:0]  commit_reg_value,
  input  logic [ROB_W-1:0] commit_reg_rob
);
  logic [XLEN-1:0]    reg_value [REG_NUM];
  logic [ROB_W-1:0]   reg_tag [REG_NUM];
  logic [REG_NUM-1:0] reg_busy;
  logic commit_en, rename_en;
  always_comb begin
    commit_en = commit_reg_config && commit_reg_id != '0;
    rename_en = rename_config && rename_rd != '0;
  end
  // priority for busy/tag: rollback, then rename, then commit clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        reg_value[i] <= '0;
        reg_tag[i] <= '0;
      end
      reg_busy <= '0;
    end else if (rdy) begin
      if (commit_en) reg_value[commit_reg_id] <= commit_reg_value;
      if (rollback) begin
        reg_busy <= '0;
        for (int i = 0; i < REG_NUM; i++) reg_tag[i] <= '0;
      end else begin
        if (commit_en && reg_tag[commit_reg_id] == commit_reg_rob) reg_busy[commit_reg_id] <= 1'b0;
        if (rename_en) begin
          reg_busy[rename_rd] <= 1'b1;
          reg_tag[rename_rd] <= rename_rob;
        end
      end
    end
  end
  reg_query_port u_rs1 (
    .id(rs1_id), .reg_value(reg_value[rs1_id]), .reg_busy(reg_busy[rs1_id]), .reg_tag(reg_tag[rs1_id]),
    .commit_reg_config(commit_reg_config), .commit_reg_id(commit_reg_id),
    .commit_reg_value(commit_reg_value), .commit_reg_rob(commit_reg_rob),
    .value(rs1_value), .busy(rs1_busy), .rob(rs1_rob)
  );
  reg_query_port u_rs2 (
    .id(rs2_id), .reg_value(reg_value[rs2_id]), .reg_busy(reg_busy[rs2_id]), .reg_tag(reg_tag[rs2_id]),
    .commit_reg_config(commit_reg_config), .commit_reg_id(commit_reg_id),
    .commit_reg_value(commit_reg_value), .commit_reg_rob(commit_reg_rob),
    .value(rs2_value), .busy(rs2_busy), .rob(rs2_rob)
  );
endmodule

// File: tb/tb_reg_rename_file.sv
// tb_reg_rename_file: directed scenarios plus random traffic against a register/tag array model
module tb_reg_rename_file;
  import reg_rename_file_pkg::*;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, rdy, rollback, rename_config, commit_reg_config;
  logic [REG_W-1:0] rename_rd, rs1_id, rs2_id, commit_reg_id;
  logic [ROB_W-1:0] rename_rob, rs1_rob, rs2_rob, commit_reg_rob;
  logic [XLEN-1:0] rs1_value, rs2_value, commit_reg_value;
  logic rs1_busy, rs2_busy;
  int n_chk = 0, n_fail = 0;
  logic [XLEN-1:0] m_val [REG_NUM];
  logic m_busy [REG_NUM];
  logic [ROB_W-1:0] m_tag [REG_NUM];

  reg_rename_file dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .rename_config(rename_config), .rename_rd(rename_rd), .rename_rob(rename_rob),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_rob(rs1_rob), .rs2_rob(rs2_rob),
    .commit_reg_config(commit_reg_config), .commit_reg_id(commit_reg_id),
    .commit_reg_value(commit_reg_value), .commit_reg_rob(commit_reg_rob)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [XLEN+ROB_W:0] ref_q(input logic [REG_W-1:0] id);
    if (id == 0) return '0;
    if (commit_reg_config && commit_reg_id == id && m_busy[id] && m_tag[id] == commit_reg_rob)
      return {commit_reg_value, 1'b0, {ROB_W{1'b0}}};
    return {m_val[id], m_busy[id], m_busy[id] ? m_tag[id] : {ROB_W{1'b0}}};
  endfunction

  task automatic tick(input bit chk_en = 1);
    logic [XLEN+ROB_W:0] e1, e2;
    @(negedge clk);
    if (chk_en) begin
      e1 = ref_q(rs1_id);
      e2 = ref_q(rs2_id);
      check("rs1_value", rs1_value, e1[XLEN+ROB_W:ROB_W+1]);
      check("rs1_busy", rs1_busy, e1[ROB_W]);
      check("rs1_rob", rs1_rob, e1[ROB_W-1:0]);
      check("rs2_value", rs2_value, e2[XLEN+ROB_W:ROB_W+1]);
      check("rs2_busy", rs2_busy, e2[ROB_W]);
      check("rs2_rob", rs2_rob, e2[ROB_W-1:0]);
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        m_val[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
      end
    end else if (rdy) begin
      if (commit_reg_config && commit_reg_id != 0) m_val[commit_reg_id] = commit_reg_value;
      if (rollback) begin
        for (int i = 0; i < REG_NUM; i++) begin
          m_busy[i] = 0; m_tag[i] = '0;
        end
      end else begin
        if (commit_reg_config && commit_reg_id != 0 && m_tag[commit_reg_id] == commit_reg_rob)
          m_busy[commit_reg_id] = 0;
        if (rename_config && rename_rd != 0) begin
          m_busy[rename_rd] = 1; m_tag[rename_rd] = rename_rob;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; rdy = 1; rollback = 0; rename_config = 0; commit_reg_config = 0;
    rename_rd = '0; rename_rob = '0; commit_reg_id = '0; commit_reg_rob = '0; commit_reg_value = '0;
  endtask

  task automatic do_rename(input int rd, input int rob);
    rename_config = 1; rename_rd = REG_W'(rd); rename_rob = ROB_W'(rob);
  endtask

  task automatic do_commit(input int id, input int rob, input logic [XLEN-1:0] v);
    commit_reg_config = 1; commit_reg_id = REG_W'(id); commit_reg_rob = ROB_W'(rob); commit_reg_value = v;
  endtask

  initial begin
    idle();
    rst = 1; rs1_id = 5; rs2_id = 0;
    tick(0);
    tick(1);
    check("rst_x5_value", rs1_value, 0);
    check("rst_x5_busy", rs1_busy, 0);
    check("rst_x0_value", rs2_value, 0);
    idle();
    do_rename(3, 7); tick();
    idle(); rs1_id = 3; #1;
    check("t2_busy", rs1_busy, 1);
    check("t2_rob", rs1_rob, 7);
    do_commit(3, 7, 32'hDEADBEEF); #1;
    check("t2_bypass_value", rs1_value, 32'hDEADBEEF);
    check("t2_bypass_busy", rs1_busy, 0);
    tick(); idle(); #1;
    check("t2_value", rs1_value, 32'hDEADBEEF);
    check("t2_busy_after", rs1_busy, 0);
    do_rename(4, 2); tick();
    do_rename(4, 5); tick();
    idle(); do_commit(4, 2, 32'h11); tick();
    idle(); rs1_id = 4; #1;
    check("t3_stale_value", rs1_value, 32'h11);
    check("t3_stale_busy", rs1_busy, 1);
    check("t3_stale_rob", rs1_rob, 5);
    do_commit(4, 5, 32'h22); tick();
    idle(); #1;
    check("t3_value", rs1_value, 32'h22);
    check("t3_busy", rs1_busy, 0);
    do_commit(6, 1, 32'h33); do_rename(6, 9); rs2_id = 6; tick();
    idle(); #1;
    check("t4_value", rs2_value, 32'h33);
    check("t4_busy", rs2_busy, 1);
    check("t4_rob", rs2_rob, 9);
    do_rename(1, 3); tick();
    do_rename(2, 4); tick();
    idle(); rollback = 1; do_rename(7, 8); do_commit(9, 0, 32'h44); tick();
    idle(); rs1_id = 1; rs2_id = 7; #1;
    check("t5_x1_busy", rs1_busy, 0);
    check("t5_x7_busy", rs2_busy, 0);
    rs1_id = 9; rs2_id = 2; #1;
    check("t5_x9_value", rs1_value, 32'h44);
    check("t5_x2_busy", rs2_busy, 0);
    rdy = 0; do_rename(8, 6); rs1_id = 8;
    repeat (3) tick();
    idle(); #1;
    check("t6_x8_busy", rs1_busy, 0);
    check("t6_x8_rob", rs1_rob, 0);
    do_rename(0, 3); do_commit(0, 3, 32'h55); rs1_id = 0; tick();
    idle(); #1;
    check("t6_x0_value", rs1_value, 0);
    check("t6_x0_busy", rs1_busy, 0);
    for (int n = 0; n < 600; n++) begin
      int cid;
      rdy = ($urandom % 8) != 0;
      rollback = ($urandom % 25) == 0;
      rename_config = $urandom % 2;
      rename_rd = REG_W'($urandom % 8);
      rename_rob = ROB_W'($urandom);
      cid = $urandom % 8;
      commit_reg_config = $urandom % 2;
      commit_reg_id = REG_W'(cid);
      commit_reg_rob = ($urandom % 3 != 0) ? m_tag[cid] : ROB_W'($urandom);
      commit_reg_value = $urandom;
      rs1_id = ($urandom % 3 == 0) ? REG_W'(cid) : REG_W'($urandom % 8);
      rs2_id = ($urandom % 3 == 0) ? rename_rd : REG_W'($urandom);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
